// File: rtl/arb_mux_if.sv
// Stream bundle for arb_mux: C packed N-bit valid/ready input channels
// and one registered output stream. The slave modport is the multiplexer's view.
interface arb_mux_if #(
  parameter int N = 8,
  parameter int C = 4
);
  localparam int CW = $clog2(C);

  logic [C*N-1:0] in_data;
  logic [C-1:0]   in_valid;
  logic [C-1:0]   in_last;
  logic [C-1:0]   in_ready;
  logic [N-1:0]   out_data;
  logic           out_last;
  logic [CW-1:0]  out_channel;
  logic           out_valid;
  logic           out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_last, out_channel, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_last, out_channel, out_valid
  );
endinterface

// File: rtl/arb_mux.sv
// Round-robin C-channel stream multiplexer with one registered output stage.
// Define ARB_MUX_LAST_EN to hold the grant on a channel until its in_last beat.
module arb_mux #(
  parameter int N = 8,
  parameter int C = 4
) (
  input  logic     clk,
  input  logic     rst,
  arb_mux_if.slave bus
);
  localparam int CW = $clog2(C);
  typedef logic [CW-1:0] ch_t;

  ch_t          ptr_q;
  logic [N-1:0] data_q;
  logic         last_q;
  ch_t          chan_q;
  logic         valid_q;

  logic         load_en;
  logic         xfer_in;
  logic [C-1:0] grant;
  ch_t          grant_ch;
  logic [N-1:0] sel_data;
  logic         sel_last;

  // Round-robin candidates: first valid at or above ptr, else first below it.
  logic [C-1:0] rr_grant;
  ch_t          rr_ch;

`ifdef ARB_MUX_LAST_EN
  typedef enum logic {
    LOCK_OPEN,
    LOCK_HELD
  } lock_state_t;

  lock_state_t lock_state_q, lock_state_d;
  ch_t         lock_ch_q, lock_ch_d;
`endif

  assign load_en = !valid_q || bus.out_ready;

  always_comb begin
    logic hi_found;
    logic lo_found;
    ch_t  hi_ch;
    ch_t  lo_ch;
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_ch    = '0;
    lo_ch    = '0;
    rr_grant = '0;
    for (int j = 0; j < C; j++) begin
      if (bus.in_valid[j]) begin
        if (j >= int'(ptr_q)) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_ch    = ch_t'(j);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_ch    = ch_t'(j);
        end
      end
    end
    rr_ch = hi_found ? hi_ch : lo_ch;
    for (int j = 0; j < C; j++) begin
      if ((hi_found || lo_found) && ch_t'(j) == rr_ch) rr_grant[j] = 1'b1;
    end
  end

`ifdef ARB_MUX_LAST_EN
  // A held lock pins the grant to its channel even while that channel is idle.
  always_comb begin
    grant    = rr_grant;
    grant_ch = rr_ch;
    if (lock_state_q == LOCK_HELD) begin
      grant    = '0;
      grant_ch = lock_ch_q;
      for (int j = 0; j < C; j++) begin
        if (ch_t'(j) == lock_ch_q && bus.in_valid[j]) grant[j] = 1'b1;
      end
    end
  end
`else
  assign grant    = rr_grant;
  assign grant_ch = rr_ch;
`endif

  // One-hot AND-OR select of the granted channel's beat.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int j = 0; j < C; j++) begin
      if (grant[j]) begin
        sel_data = bus.in_data[j*N +: N];
        sel_last = bus.in_last[j];
      end
    end
  end

  assign xfer_in      = !rst && load_en && (|grant);
  assign bus.in_ready = (rst || !load_en) ? '0 : grant;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      ptr_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else if (xfer_in) begin
      data_q  <= sel_data;
      last_q  <= sel_last;
      chan_q  <= grant_ch;
      valid_q <= 1'b1;
      ptr_q   <= (grant_ch == ch_t'(C - 1)) ? '0 : grant_ch + 1'b1;
    end else if (bus.out_ready) begin
      // Output drained with nothing new: payload fields hold their last value.
      valid_q <= 1'b0;
    end
  end

`ifdef ARB_MUX_LAST_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state_q <= LOCK_OPEN;
      lock_ch_q    <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_ch_q    <= lock_ch_d;
    end
  end

  always_comb begin
    lock_state_d = lock_state_q;
    lock_ch_d    = lock_ch_q;
    if (xfer_in) begin
      if (sel_last) begin
        lock_state_d = LOCK_OPEN;
      end else begin
        lock_state_d = LOCK_HELD;
        lock_ch_d    = grant_ch;
      end
    end
  end
`endif

  assign bus.out_data    = data_q;
  assign bus.out_last    = last_q;
  assign bus.out_channel = chan_q;
  assign bus.out_valid   = valid_q;
endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux (N=8, C=4). Output word compared as
// {out_valid, out_last, out_channel, out_data}; inputs change 1ns after posedge.
module tb_arb_mux;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  arb_mux_if #(.N(8), .C(4)) bus ();
  arb_mux #(.N(8), .C(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [11:0] obs;
  assign obs = {bus.out_valid, bus.out_last, bus.out_channel, bus.out_data};

  localparam logic [31:0] ALL_A = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.in_last   = '0;
    bus.in_data   = ALL_A;
    bus.out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL reset_out: got %h want %h", obs, 12'h000);
    end
    checks++;
    if (bus.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b want %b", bus.in_ready, 4'b0000);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_ready: got %b want %b", bus.in_ready, 4'b0001);
    end
  endtask

  task automatic test_round_robin();
    logic [11:0] exp_out[5] = '{12'h8A0, 12'h9A1, 12'hAA2, 12'hBA3, 12'h8A0};
    logic [3:0]  exp_rdy[5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    do_reset();
    bus.in_valid = 4'b1111;
    bus.in_data  = ALL_A;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (obs !== exp_out[k]) begin
        errors++;
        $display("FAIL rr_beat%0d: got %h want %h", k, obs, exp_out[k]);
      end
      checks++;
      if (bus.in_ready !== exp_rdy[k]) begin
        errors++;
        $display("FAIL rr_ready%0d: got %b want %b", k, bus.in_ready, exp_rdy[k]);
      end
    end
    bus.in_valid = '0;
  endtask

  task automatic test_sparse();
    do_reset();
    bus.in_valid = 4'b0100;
    bus.in_data  = {8'h00, 8'h5C, 8'h00, 8'h00};
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (obs !== 12'hA5C) begin
        errors++;
        $display("FAIL sparse_beat%0d: got %h want %h", k, obs, 12'hA5C);
      end
      checks++;
      if (bus.in_ready !== 4'b0100) begin
        errors++;
        $display("FAIL sparse_ready%0d: got %b want %b", k, bus.in_ready, 4'b0100);
      end
    end
    bus.in_valid = 4'b1111;
    #1;
    checks++;
    if (bus.in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL sparse_ptr: got %b want %b", bus.in_ready, 4'b1000);
    end
    bus.in_valid = 4'b0000;
    tick();
    checks++;
    if (obs !== 12'h25C) begin
      errors++;
      $display("FAIL sparse_drain: got %h want %h", obs, 12'h25C);
    end
    tick();
    bus.in_valid = 4'b1111;
    #1;
    checks++;
    if (bus.in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL sparse_idle_ptr: got %b want %b", bus.in_ready, 4'b1000);
    end
    bus.in_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.in_valid = 4'b1111;
    bus.in_data  = ALL_A;
    tick();
    tick();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (obs !== 12'h9A1) begin
        errors++;
        $display("FAIL bp_hold%0d: got %h want %h", k, obs, 12'h9A1);
      end
      checks++;
      if (bus.in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready%0d: got %b want %b", k, bus.in_ready, 4'b0000);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_release_ready: got %b want %b", bus.in_ready, 4'b0100);
    end
    tick();
    checks++;
    if (obs !== 12'hAA2) begin
      errors++;
      $display("FAIL bp_next: got %h want %h", obs, 12'hAA2);
    end
    bus.in_valid = '0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.in_valid = 4'b1111;
    bus.in_data  = ALL_A;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_ready: got %b want %b", bus.in_ready, 4'b0000);
    end
    tick();
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL midrst_out: got %h want %h", obs, 12'h000);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_restart: got %b want %b", bus.in_ready, 4'b0001);
    end
    tick();
    checks++;
    if (obs !== 12'h8A0) begin
      errors++;
      $display("FAIL midrst_beat: got %h want %h", obs, 12'h8A0);
    end
    bus.in_valid = '0;
  endtask

`ifdef ARB_MUX_LAST_EN
  task automatic test_lock();
    logic [3:0]  vld[6]  = '{4'b0010, 4'b0011, 4'b0001, 4'b0001, 4'b0011, 4'b0001};
    logic [7:0]  d1[6]   = '{8'h21, 8'h22, 8'h00, 8'h00, 8'h23, 8'h00};
    logic [3:0]  lst[6]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    logic [3:0]  rdy[6]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0001};
    logic [11:0] outw[6] = '{12'h921, 12'h922, 12'h122, 12'h122, 12'hD23, 12'h810};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      bus.in_valid = vld[k];
      bus.in_last  = lst[k];
      bus.in_data  = {8'h00, 8'h00, d1[k], 8'h10};
      #1;
      checks++;
      if (bus.in_ready !== rdy[k]) begin
        errors++;
        $display("FAIL lock_ready%0d: got %b want %b", k, bus.in_ready, rdy[k]);
      end
      tick();
      checks++;
      if (obs !== outw[k]) begin
        errors++;
        $display("FAIL lock_beat%0d: got %h want %h", k, obs, outw[k]);
      end
    end
    bus.in_valid = '0;
    bus.in_last  = '0;
  endtask
`else
  task automatic test_last_passthrough();
    do_reset();
    bus.in_valid = 4'b0010;
    bus.in_last  = 4'b0000;
    bus.in_data  = {8'h00, 8'h00, 8'h21, 8'h10};
    tick();
    checks++;
    if (obs !== 12'h921) begin
      errors++;
      $display("FAIL last_beat0: got %h want %h", obs, 12'h921);
    end
    bus.in_valid = 4'b0011;
    bus.in_last  = 4'b0001;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL last_nolock_ready: got %b want %b", bus.in_ready, 4'b0001);
    end
    tick();
    checks++;
    if (obs !== 12'hC10) begin
      errors++;
      $display("FAIL last_beat1: got %h want %h", obs, 12'hC10);
    end
    bus.in_valid = '0;
    bus.in_last  = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_sparse();
    test_backpressure();
    test_mid_reset();
`ifdef ARB_MUX_LAST_EN
    test_lock();
`else
    test_last_passthrough();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised, registered, multi-channel stream multiplexer. Merges C valid/ready input streams of N-bit data into one output stream. A round-robin arbiter picks the channel and a single output register stage holds the result. It sits wherever several producers share one consumer (e.g. UART TX, shared bus master) and replaces ad-hoc 2:1 select logic when the channels are independent flow-controlled sources.

## Interface
Parameters:
- N, 8, data width per channel (≥1)
- C, 4, channel count (≥2)

Ports:
- clk  in  1  single clock; all state updates on posedge clk
- rst  in  1  synchronous, active-high reset
- in_data  in  C*N  packed inputs; channel i at [i*N +: N]
- in_valid  in  C  per-channel valid
- in_last  in  C  per-channel end-of-packet marker
- in_ready  out  C  per-channel ready; at most one bit high per cycle
- out_data  out  N  registered output data
- out_last  out  1  registered in_last of the transferred beat
- out_channel  out  $clog2(C)  index of the channel that produced out_data
- out_valid  out  1  output register holds a beat
- out_ready  in  1  consumer accepts the beat

## Operation
- Transfers:
  - Input beat transfers on in_valid[i] & in_ready[i].
  - Output beat transfers on out_valid & out_ready.
- load_en = !out_valid | out_ready. The output register loads only when load_en is high.
- Arbitration (combinational):
  - Among channels with in_valid high, grant the first one found searching upward (with wrap) from ptr.
  - in_ready[i] = load_en & grant[i]. No grant when no channel is valid.
- On an input transfer from channel k:
  - out_data ← channel k data, out_last ← in_last[k], out_channel ← k, out_valid ← 1.
  - ptr ← (k+1) mod C.
- On an output transfer with no input transfer: out_valid ← 0. The data, last and channel outputs hold their values.
- Simultaneous output and input transfer: the register is replaced in the same cycle, with no bubble.
- in_ready must not depend on in_valid of the same channel beyond grant selection. An invalid channel never sees in_ready high.
- Data is never duplicated or dropped. Per-channel order is preserved.
- Reset values: out_valid=0, out_data=0, out_last=0, out_channel=0, ptr=0, lock cleared. Any held beat is discarded.
- Reset mid-operation behaves the same. in_ready is all-zero during the cycle rst is high.

## Timing
- Latency: 1 cycle from the input transfer edge to out_valid high.
- Throughput: 1 beat/cycle sustained when out_ready is held high.
- Fairness:
  - With all C channels continuously valid and out_ready=1, grants rotate 0,1,…,C-1,0,…
  - Each channel waits at most C-1 grants.
- Backpressure: with out_ready=0 and out_valid=1, all in_ready are 0 and all outputs are stable.
- ptr advances only on an input transfer, never on idle cycles.

## Configuration
- ARB_MUX_LAST_EN defined (packet lock):
  - After a transfer from channel k with in_last[k]=0, a lock is set to k.
  - While locked, grant goes only to k (in_ready[k]=load_en & in_valid[k]). Other channels get ready=0, even if k is idle.
  - The lock clears on a transfer from k with in_last[k]=1. ptr then updates as normal.
  - Reset clears the lock.
- ARB_MUX_LAST_EN undefined:
  - Arbitration runs on every beat.
  - in_last is only passed through to out_last.
  - No lock state is synthesised.

## Test plan
- Reset check: assert rst for 2 cycles, inputs all valid. Required: out_valid=0, out_data=0, out_channel=0, in_ready=0. In the first cycle after reset, in_ready=4'b0001.
- Round-robin (C=4, N=8): all channels valid with data 8'hA0+i, out_ready=1. Required outputs from cycle 1: A0,A1,A2,A3,A0 with out_channel 0,1,2,3,0 at one beat/cycle.
- Sparse: only channel 2 valid (8'h5C) for 3 cycles. Required: three beats of 5C, out_channel=2, no gaps. ptr=3 afterwards.
- Backpressure: out_ready=0 for 4 cycles while holding beat A1. Required: out_data stays A1, all in_ready=0. When out_ready returns high, A2 follows with no loss.
- Mid-stream reset: rst pulses while out_valid=1. Required: out_valid=0 the next cycle, and arbitration restarts at channel 0.
- With ARB_MUX_LAST_EN: channel 1 sends a 3-beat packet (last on beat 3) while channel 0 is also valid. Channel 1 goes invalid for 2 cycles mid-packet. Required: no channel-0 beat is granted until channel 1's last beat transfers; channel 0 is granted next.
